// File: rtl/k8088_mem.sv
// k8088_mem: SRAM arbiter between the k8088 core and video fetch; optional video via K8088_MEM_VIDEO_EN
//   clock/reset_n                        25 MHz clock, async active-low reset
//   cpu_address/cpu_out/cpu_we           core access (always pending), cpu_in read byte, cpu_chipen step pulse
//   sram_addr/sram_dq_in/sram_dq_out     16-bit SRAM word bus
//   sram_oe_n/we_n/ub_n/lb_n             active-low SRAM strobes
//   vid_req/vid_addr/vid_data/vid_ack    video word fetch (constant 0 outputs when macro undefined)
module k8088_mem #(
  parameter int WAIT = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [19:0] cpu_address,
  input  logic [7:0]  cpu_out,
  input  logic        cpu_we,
  output logic [7:0]  cpu_in,
  output logic        cpu_chipen,
  output logic [18:0] sram_addr,
  input  logic [15:0] sram_dq_in,
  output logic [15:0] sram_dq_out,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n,
  input  logic        vid_req,
  input  logic [18:0] vid_addr,
  output logic [15:0] vid_data,
  output logic        vid_ack
);
  typedef enum logic [2:0] {IDLE, CPU_RD, CPU_WR, VID_RD, DONE} state_t;
  localparam logic [2:0] LAST = 3'(WAIT);
  state_t state, state_nx, acc;
  logic [2:0] cnt;
  logic last, rd, wr, cpu_side, vid_side;
  assign last = cnt == LAST;
  // acc remembers which access DONE is finishing, so DONE can keep address/data stable and pick its pulse
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= 3'd0;
      acc   <= IDLE;
    end else begin
      state <= state_nx;
      cnt   <= (state inside {CPU_RD, CPU_WR, VID_RD}) && !last ? cnt + 3'd1 : 3'd0;
      if (state == IDLE) acc <= state_nx;
    end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        state_nx = cpu_we ? CPU_WR : CPU_RD;
`ifdef K8088_MEM_VIDEO_EN
        if (vid_req) state_nx = VID_RD;
`endif
      end
      CPU_RD, CPU_WR, VID_RD: state_nx = last ? DONE : state;
      default: state_nx = IDLE;
    endcase
  end
  // Strobes decode straight from state so an async reset releases them without a clock edge
  always_comb begin
    rd          = state == CPU_RD || state == VID_RD;
    wr          = state == CPU_WR;
    cpu_side    = state == CPU_RD || wr || (state == DONE && acc != VID_RD);
    vid_side    = state == VID_RD || (state == DONE && acc == VID_RD);
    sram_oe_n   = !rd;
    sram_we_n   = !wr;
    sram_ub_n   = wr ? ~cpu_address[0] : !rd;
    sram_lb_n   = wr ? cpu_address[0] : !rd;
    sram_addr   = cpu_side ? cpu_address[19:1] : vid_side ? vid_addr : 19'd0;
    sram_dq_out = (wr || (state == DONE && acc == CPU_WR)) ? {2{cpu_out}} : 16'd0;
    cpu_chipen  = state == DONE && acc != VID_RD;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) cpu_in <= 8'h00;
    else if (state == CPU_RD && last) cpu_in <= cpu_address[0] ? sram_dq_in[15:8] : sram_dq_in[7:0];
`ifdef K8088_MEM_VIDEO_EN
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) vid_data <= 16'h0000;
    else if (state == VID_RD && last) vid_data <= sram_dq_in;
  assign vid_ack = state == DONE && acc == VID_RD;
`else
  logic unused_vid_req;
  assign unused_vid_req = vid_req;
  assign vid_data = 16'h0000;
  assign vid_ack  = 1'b0;
`endif
endmodule

// File: doc/k8088_mem.md
K8088_MEM -- requirements
Module: k8088_mem

Interface
REQ-001 Parameter WAIT, default 1, range 0..7: extra SRAM access cycles beyond the minimum one.
REQ-002 clock  in  1  system clock, 25 MHz.
REQ-003 reset_n  in  1  reset, asynchronous, active-low.
REQ-004 cpu_address  in  20  byte address from the k8088 core.
REQ-005 cpu_out  in  8  write data from the core.
REQ-006 cpu_we  in  1  core write request (1 = write, 0 = read).
REQ-007 cpu_in  out  8  registered read data to the core.
REQ-008 cpu_chipen  out  1  one-cycle step enable to the core.
REQ-009 sram_addr  out  19  SRAM word address.
REQ-010 sram_dq_in  in  16  SRAM read data.
REQ-011 sram_dq_out  out  16  SRAM write data.
REQ-012 sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  out  1 each  SRAM strobes, active-low.
REQ-013 vid_req  in  1  video fetch request, level, held until ack.
REQ-014 vid_addr  in  19  video word address.
REQ-015 vid_data  out  16  video read data, valid when vid_ack=1.
REQ-016 vid_ack  out  1  one-cycle completion pulse.

Function
REQ-017 The FSM SHALL have states IDLE, CPU_RD, CPU_WR, VID_RD and DONE, plus a 3-bit wait counter.
REQ-018 In IDLE with vid_req=1, the FSM SHALL go to VID_RD; video has priority over the CPU.
REQ-019 In IDLE with no video request, the FSM SHALL go to CPU_WR when cpu_we=1, otherwise to CPU_RD; the core always has a pending access.
REQ-020 CPU_RD, CPU_WR and VID_RD SHALL each last exactly WAIT+1 cycles, counted by the wait counter.
REQ-021 In CPU_RD, sram_oe_n SHALL be 0; on the last cycle, cpu_in SHALL latch sram_dq_in[15:8] if cpu_address[0]=1, else sram_dq_in[7:0].
REQ-022 In CPU_WR, sram_we_n SHALL be 0 and sram_dq_out SHALL be {cpu_out, cpu_out}.
REQ-023 In CPU_WR, sram_ub_n SHALL be ~cpu_address[0] and sram_lb_n SHALL be cpu_address[0].
REQ-024 In CPU_RD and VID_RD, both sram_ub_n and sram_lb_n SHALL be 0.
REQ-025 sram_addr SHALL be cpu_address[19:1] in CPU_RD, CPU_WR and DONE-after-CPU, and vid_addr in VID_RD.
REQ-026 Address and data SHALL remain stable for one cycle after sram_we_n rises, in DONE.
REQ-027 After a CPU access, DONE SHALL assert cpu_chipen=1 for exactly one cycle and then return to IDLE.
REQ-028 A CPU access SHALL therefore take WAIT+3 cycles from IDLE to IDLE.
REQ-029 VID_RD SHALL latch sram_dq_in into vid_data on its last cycle.
REQ-030 VID_RD SHALL pulse vid_ack=1 in the following DONE cycle, with cpu_chipen=0.
REQ-031 vid_data SHALL hold its value until the next video access completes.
REQ-032 A vid_req raised during a CPU access SHALL be served at the next IDLE; an access in progress is never preempted.
REQ-033 cpu_chipen and vid_ack SHALL never both be 1.
REQ-034 Outside active states, sram_oe_n, sram_we_n, sram_ub_n and sram_lb_n SHALL all be 1.
REQ-035 Address 20'hFFFFF SHALL map to word 19'h7FFFF, upper byte; there is no wrap logic.

Reset
REQ-036 While reset_n=0, the block SHALL asynchronously force state IDLE, counter 0, cpu_chipen=0, vid_ack=0, cpu_in=8'h00, vid_data=16'h0000, sram_addr=0, sram_dq_out=0, and all SRAM strobes to 1.
REQ-037 Reset mid-write SHALL deassert sram_we_n in the same cycle, without waiting for a clock edge.
REQ-038 After reset release, the first action SHALL be an IDLE evaluation on the next edge.

Configuration
REQ-039 Macro K8088_MEM_VIDEO_EN: when defined, video arbitration SHALL operate as specified above.
REQ-040 When K8088_MEM_VIDEO_EN is undefined, vid_req SHALL be ignored, VID_RD SHALL be absent, vid_ack SHALL be constant 0, and vid_data SHALL be constant 16'h0000.

Verification
REQ-041 WAIT=1, core read at 20'hFFFF0, SRAM word 7FFF8 = 16'hEA5A -> cpu_in=8'h5A, oe_n low 2 cycles, cpu_chipen single pulse 4 cycles after IDLE sample.
REQ-042 Core write 8'h3C to 20'h00401 -> sram_addr=19'h00200, dq_out=16'h3C3C, ub_n=0, lb_n=1, we_n low for WAIT+1 cycles, then stable one cycle.
REQ-043 vid_req and core read pending together in IDLE -> VID_RD first, vid_ack pulse, then CPU access; no overlap of strobes.
REQ-044 reset_n low in the middle of CPU_WR cycle 2 -> sram_we_n=1 immediately, all outputs at reset values, no cpu_chipen.
REQ-045 WAIT=0 back-to-back core reads -> cpu_chipen every 3 cycles.
REQ-046 With K8088_MEM_VIDEO_EN undefined and vid_req held at 1 -> vid_ack never asserts and core reads keep the 3+WAIT cadence.
